hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard unit for the 5-stage RV32 core.
- Adds a per-register scoreboard for the variable-latency multiply/divide unit and per-operand "uses" qualification to remove false stalls.
- Adds a memory wait-state freeze (data bus not ready) and a counted post-reset flush window.
- Sits beside the datapath; drives stall, flush and EX-stage forwarding selects.

Parameters:
- NUM_REGS, 32, architectural registers tracked; register 0 is never tracked.
- REG_AW, 5, register index width (clog2 NUM_REGS).
- RSRC_W, 3, ResultSrc encoding width.
- LOAD_SRC, 3'b001, ResultSrc value marking a load.
- RESET_FLUSH, 2, cycles FlushD/FlushE stay high after reset release (1..15).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  REG_AW  decode-stage source indices
- UsesRs1D, UsesRs2D  in  1  decode instruction actually reads Rs1D / Rs2D
- RdD  in  REG_AW  decode-stage destination
- RegWriteD  in  1  decode instruction writes RdD
- Rs1E, Rs2E, RdE  in  REG_AW  execute-stage indices
- ResultSrcE  in  RSRC_W  execute result source
- PCSrcE  in  1  taken branch/jump redirect
- MdIssueE  in  1  execute instruction starts a mul/div op
- RdM  in  REG_AW;  RegWriteM  in  1  memory-stage writeback info
- MemReadyM  in  1  data bus ready (0 = wait state)
- RdW  in  REG_AW;  RegWriteW  in  1  writeback-stage info
- MdDoneW  in  1  mul/div result written back this cycle
- MdRdW  in  REG_AW  destination of completing mul/div
- StallF, StallD, StallE, StallM  out  1  hold stage registers
- FlushD, FlushE  out  1  bubble insertion
- ForwardAE, ForwardBE  out  2  00 regfile, 01 from W, 10 from M
- MdBusy  out  1  mul/div unit occupied
- PendingMask  out  NUM_REGS  scoreboard contents (bit 0 always 0)

Behaviour:
- Reset (rst=0, async):
  - pending cleared; MdBusy=0; flush counter loaded with RESET_FLUSH.
  - While rst=0: FlushD=FlushE=1, all stalls 0, forwards 00.
- Flush window: after rst rises, FlushD=FlushE=1 for exactly RESET_FLUSH cycles; the counter decrements per clock.
- Scoreboard update, per clock:
  - Set pending[RdE] when MdIssueE & !StallE & !FlushE & RdE!=0.
  - Clear pending[MdRdW] when MdDoneW.
  - Set and clear of the same index in one cycle leave the bit set.
- MdBusy: set on accepted issue, cleared on MdDoneW; issue and done in the same cycle leave it set.
- Hazard terms:
  - rawD = (UsesRs1D & pending[Rs1D]) | (UsesRs2D & pending[Rs2D]); a bit being cleared this cycle by MdDoneW counts as not pending (same-cycle bypass).
  - wawD = RegWriteD & RdD!=0 & pending[RdD] (same bypass applies).
  - lwStall = ResultSrcE==LOAD_SRC & RdE!=0 & ((UsesRs1D & Rs1D==RdE) | (UsesRs2D & Rs2D==RdE)).
  - mdStall = MdIssueE & MdBusy & !MdDoneW; also asserts StallE.
  - hold = rawD | wawD | lwStall.
- Freeze: MemReadyM=0 gives StallF=StallD=StallE=StallM=1 and FlushD=FlushE=0 (unless in reset or the flush window). This overrides all other terms; PCSrcE is re-evaluated after unfreeze because E holds.
- Otherwise:
  - StallF = StallD = hold | mdStall.
  - StallE = mdStall; StallM = 0.
  - FlushD = PCSrcE.
  - FlushE = PCSrcE | (hold & !mdStall).
- Forwarding (combinational; A shown, B identical with Rs2E):
  - 10 if RegWriteM & RdM==Rs1E & Rs1E!=0.
  - else 01 if RegWriteW & RdW==Rs1E & Rs1E!=0.
  - else 00.
  - M has priority over W.
- All outputs except PendingMask, MdBusy and the flush counter are combinational from inputs plus state; no added latency.

Decomposition:
- Shared package core_hazard_pkg: FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10, RESULTSRC encodings (LOAD=3'b001 etc.), REG_AW.
- One sub-module, hazard_sb_regs: pending bit array with set/clear ports and bypassed read ports.

Test Plan:
- Reset release with RESET_FLUSH=2 -> FlushD/FlushE high for exactly 2 clocks after rst rises, then 0.
- div issue RdE=5; next decode uses x5 (UsesRs1D=1) -> StallD=StallF=1, FlushE=1 until MdDoneW with MdRdW=5; released in the MdDoneW cycle.
- Load RdE=7 in E; decode Rs2D=7 with UsesRs2D=0 -> no stall. Same with UsesRs2D=1 -> one stall cycle plus FlushE.
- RegWriteM RdM=3 and RegWriteW RdW=3, Rs1E=3 -> ForwardAE=10. Rs1E=0 -> 00.
- MemReadyM=0 for 3 cycles with PCSrcE=1 -> all stalls 1, FlushD=0 for 3 cycles. Then FlushD=1 in the next cycle.
- Second MdIssueE while MdBusy -> StallE=1 until MdDoneW; rst pulled low mid-op -> PendingMask=0 and MdBusy=0 immediately.

Source files
------------

// File: rtl/core_hazard_pkg.sv
// core_hazard_pkg
//   Shared constants for the RV32 hazard logic: forwarding-select codes,
//   ResultSrc encodings, default register-index geometry and the width
//   of the post-reset flush counter. Also holds the forwarding priority
//   helper so every forwarding path resolves M-over-W the same way.
package core_hazard_pkg;

    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;
    localparam int RSRC_W   = 3;
    localparam int FLUSH_CW = 4;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic [2:0] {
        RESULTSRC_ALU  = 3'b000,
        RESULTSRC_LOAD = 3'b001,
        RESULTSRC_PC4  = 3'b010,
        RESULTSRC_IMM  = 3'b011,
        RESULTSRC_MD   = 3'b100
    } resultsrc_e;

    // Memory stage is younger than writeback, so its value wins.
    function automatic logic [1:0] fwd_select(input logic m_hit, input logic w_hit);
        logic [1:0] sel;
        if (m_hit) begin
            sel = FWD_M;
        end else if (w_hit) begin
            sel = FWD_W;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_sb_regs.sv
// hazard_sb_regs
//   Pending-result bit array for the multiply/divide unit. One bit per
//   architectural register; register 0 is never marked.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   set_en, set_idx     mark a register as awaiting a mul/div result
//   clr_en, clr_idx     mul/div result written back for this register
//   rdN_idx / rdN_pend  read ports; a bit cleared this cycle reads as 0
//   mask                raw register contents (bit 0 always 0)
module hazard_sb_regs #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [REG_AW-1:0]   set_idx,
    input  logic                clr_en,
    input  logic [REG_AW-1:0]   clr_idx,
    input  logic [REG_AW-1:0]   rd1_idx,
    input  logic [REG_AW-1:0]   rd2_idx,
    input  logic [REG_AW-1:0]   rd3_idx,
    output logic                rd1_pend,
    output logic                rd2_pend,
    output logic                rd3_pend,
    output logic [NUM_REGS-1:0] mask
);
    import core_hazard_pkg::*;

    logic [NUM_REGS-1:0] pend_r;
    logic [NUM_REGS-1:0] pend_next_s;
    logic [NUM_REGS-1:0] set_vec_s;
    logic [NUM_REGS-1:0] clr_vec_s;

    // Decode set/clear strobes; a set in the same cycle as a clear wins.
    always_comb begin
        set_vec_s = {NUM_REGS{1'b0}};
        clr_vec_s = {NUM_REGS{1'b0}};
        for (int i = 1; i < NUM_REGS; i++) begin
            if (set_en && (set_idx == REG_AW'(i))) begin
                set_vec_s[i] = 1'b1;
            end else begin
                set_vec_s[i] = 1'b0;
            end
            if (clr_en && (clr_idx == REG_AW'(i))) begin
                clr_vec_s[i] = 1'b1;
            end else begin
                clr_vec_s[i] = 1'b0;
            end
        end
        pend_next_s = (pend_r | set_vec_s) & ~(clr_vec_s & ~set_vec_s);
    end

    // Pending bit storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r <= {NUM_REGS{1'b0}};
        end else begin
            pend_r <= pend_next_s;
        end
    end

    // Bypassed reads: a result landing this cycle no longer blocks decode.
    always_comb begin
        rd1_pend = pend_r[rd1_idx];
        rd2_pend = pend_r[rd2_idx];
        rd3_pend = pend_r[rd3_idx];
        if (clr_en && (clr_idx == rd1_idx)) begin
            rd1_pend = 1'b0;
        end else begin
            rd1_pend = pend_r[rd1_idx];
        end
        if (clr_en && (clr_idx == rd2_idx)) begin
            rd2_pend = 1'b0;
        end else begin
            rd2_pend = pend_r[rd2_idx];
        end
        if (clr_en && (clr_idx == rd3_idx)) begin
            rd3_pend = 1'b0;
        end else begin
            rd3_pend = pend_r[rd3_idx];
        end
    end

    assign mask = pend_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard unit for the 5-stage RV32 core: load-use interlock, mul/div
//   register scoreboard (RAW/WAW on decode), mul/div structural stall,
//   data-bus wait-state freeze, branch flush, post-reset flush window and
//   EX-stage forwarding selects.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   Rs1D/Rs2D/UsesRs1D/UsesRs2D     decode sources and whether they are read
//   RdD/RegWriteD                   decode destination
//   Rs1E/Rs2E/RdE/ResultSrcE        execute-stage indices and result source
//   PCSrcE, MdIssueE                redirect, mul/div issue in execute
//   RdM/RegWriteM/MemReadyM         memory-stage writeback info, bus ready
//   RdW/RegWriteW/MdDoneW/MdRdW     writeback info, mul/div completion
//   StallF/D/E/M, FlushD/E          pipeline control
//   ForwardAE/BE                    00 regfile, 01 from W, 10 from M
//   MdBusy, PendingMask             mul/div occupancy, scoreboard contents
module hazard_scoreboard #(
    parameter int                               NUM_REGS    = core_hazard_pkg::NUM_REGS,
    parameter int                               REG_AW      = core_hazard_pkg::REG_AW,
    parameter int                               RSRC_W      = core_hazard_pkg::RSRC_W,
    parameter logic [core_hazard_pkg::RSRC_W-1:0] LOAD_SRC  = core_hazard_pkg::RESULTSRC_LOAD,
    parameter int                               RESET_FLUSH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_AW-1:0]   Rs1D,
    input  logic [REG_AW-1:0]   Rs2D,
    input  logic                UsesRs1D,
    input  logic                UsesRs2D,
    input  logic [REG_AW-1:0]   RdD,
    input  logic                RegWriteD,
    input  logic [REG_AW-1:0]   Rs1E,
    input  logic [REG_AW-1:0]   Rs2E,
    input  logic [REG_AW-1:0]   RdE,
    input  logic [RSRC_W-1:0]   ResultSrcE,
    input  logic                PCSrcE,
    input  logic                MdIssueE,
    input  logic [REG_AW-1:0]   RdM,
    input  logic                RegWriteM,
    input  logic                MemReadyM,
    input  logic [REG_AW-1:0]   RdW,
    input  logic                RegWriteW,
    input  logic                MdDoneW,
    input  logic [REG_AW-1:0]   MdRdW,
    output logic                StallF,
    output logic                StallD,
    output logic                StallE,
    output logic                StallM,
    output logic                FlushD,
    output logic                FlushE,
    output logic [1:0]          ForwardAE,
    output logic [1:0]          ForwardBE,
    output logic                MdBusy,
    output logic [NUM_REGS-1:0] PendingMask
);
    import core_hazard_pkg::*;

    localparam logic [REG_AW-1:0] X0 = {REG_AW{1'b0}};

    logic [FLUSH_CW-1:0] flush_cnt_r;
    logic                md_busy_r;
    logic                win_s;
    logic                pend1_s, pend2_s, pend3_s;
    logic                rawd_s, wawd_s, lwstall_s, mdstall_s, hold_s;
    logic                issue_ok_s, sb_set_s;
    logic                m_hit_a_s, w_hit_a_s, m_hit_b_s, w_hit_b_s;

    hazard_sb_regs #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (sb_set_s),
        .set_idx  (RdE),
        .clr_en   (MdDoneW),
        .clr_idx  (MdRdW),
        .rd1_idx  (Rs1D),
        .rd2_idx  (Rs2D),
        .rd3_idx  (RdD),
        .rd1_pend (pend1_s),
        .rd2_pend (pend2_s),
        .rd3_pend (pend3_s),
        .mask     (PendingMask)
    );

    // Hazard terms from decode/execute state.
    always_comb begin
        win_s     = (flush_cnt_r != {FLUSH_CW{1'b0}});
        rawd_s    = (UsesRs1D & pend1_s) | (UsesRs2D & pend2_s);
        wawd_s    = RegWriteD & (RdD != X0) & pend3_s;
        lwstall_s = (ResultSrcE == LOAD_SRC) & (RdE != X0) &
                    ((UsesRs1D & (Rs1D == RdE)) | (UsesRs2D & (Rs2D == RdE)));
        // A completing op frees the unit in time for a waiting issue.
        mdstall_s = MdIssueE & md_busy_r & ~MdDoneW;
        hold_s    = rawd_s | wawd_s | lwstall_s;
    end

    // Stall/flush priority: reset, then bus freeze, then normal hazards.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b1;
        FlushE = 1'b1;
        if (!rst) begin
            StallF = 1'b0;
            StallD = 1'b0;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (!MemReadyM) begin
            // Whole pipe holds; a pending redirect is re-seen once E moves.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushD = win_s;
            FlushE = win_s;
        end else begin
            StallF = hold_s | mdstall_s;
            StallD = hold_s | mdstall_s;
            StallE = mdstall_s;
            StallM = 1'b0;
            FlushD = PCSrcE | win_s;
            // When E is held for mul/div the bubble must not overwrite it.
            FlushE = PCSrcE | (hold_s & ~mdstall_s) | win_s;
        end
    end

    // An issue is accepted only if the instruction actually leaves E.
    always_comb begin
        issue_ok_s = MdIssueE & ~StallE & ~FlushE;
        sb_set_s   = issue_ok_s & (RdE != X0);
    end

    // Forwarding selects for both EX operands.
    always_comb begin
        m_hit_a_s = RegWriteM & (RdM == Rs1E) & (Rs1E != X0);
        w_hit_a_s = RegWriteW & (RdW == Rs1E) & (Rs1E != X0);
        m_hit_b_s = RegWriteM & (RdM == Rs2E) & (Rs2E != X0);
        w_hit_b_s = RegWriteW & (RdW == Rs2E) & (Rs2E != X0);
        if (!rst) begin
            ForwardAE = FWD_REG;
            ForwardBE = FWD_REG;
        end else begin
            ForwardAE = fwd_select(m_hit_a_s, w_hit_a_s);
            ForwardBE = fwd_select(m_hit_b_s, w_hit_b_s);
        end
    end

    // Mul/div occupancy; issue wins over a same-cycle completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_busy_r <= 1'b0;
        end else if (issue_ok_s) begin
            md_busy_r <= 1'b1;
        end else if (MdDoneW) begin
            md_busy_r <= 1'b0;
        end else begin
            md_busy_r <= md_busy_r;
        end
    end

    // Post-reset flush window counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt_r <= FLUSH_CW'(RESET_FLUSH);
        end else if (flush_cnt_r != {FLUSH_CW{1'b0}}) begin
            flush_cnt_r <= flush_cnt_r - {{(FLUSH_CW-1){1'b0}}, 1'b1};
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign MdBusy = md_busy_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int RF = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4:0] Rs1D = 5'd0, Rs2D = 5'd0, RdD = 5'd0, Rs1E = 5'd0, Rs2E = 5'd0, RdE = 5'd0;
    logic [4:0] RdM = 5'd0, RdW = 5'd0, MdRdW = 5'd0;
    logic UsesRs1D = 1'b0, UsesRs2D = 1'b0, RegWriteD = 1'b0, PCSrcE = 1'b0, MdIssueE = 1'b0;
    logic RegWriteM = 1'b0, MemReadyM = 1'b1, RegWriteW = 1'b0, MdDoneW = 1'b0;
    logic [2:0] ResultSrcE = 3'd0;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, MdBusy;
    logic [1:0] ForwardAE, ForwardBE;
    logic [31:0] PendingMask;

    always #5 clk = ~clk;

    hazard_scoreboard #(.RESET_FLUSH(RF)) dut (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .UsesRs1D(UsesRs1D), .UsesRs2D(UsesRs2D),
        .RdD(RdD), .RegWriteD(RegWriteD), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MdIssueE(MdIssueE), .RdM(RdM),
        .RegWriteM(RegWriteM), .MemReadyM(MemReadyM), .RdW(RdW), .RegWriteW(RegWriteW),
        .MdDoneW(MdDoneW), .MdRdW(MdRdW), .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE),
        .ForwardBE(ForwardBE), .MdBusy(MdBusy), .PendingMask(PendingMask)
    );

    typedef struct {
        bit rst;
        bit [4:0] rs1d, rs2d, rdd, rs1e, rs2e, rde, rdm, rdw, mdrdw;
        bit u1, u2, rwd, pcsrc, mdissue, rwm, memrdy, rww, mddone;
        bit [2:0] rsrc;
    } in_t;

    typedef struct packed {
        logic stallf, stalld, stalle, stallm, flushd, flushe;
        logic [1:0] fwda, fwdb;
        logic busy;
        logic [31:0] mask;
    } out_t;

    typedef struct {
        string nm;
        in_t   i;
        out_t  e;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    vec_t tbl[$];

    // Reference model state: which registers await a mul/div result.
    bit m_pend[32];
    bit m_busy;
    int m_cnt;

    function automatic in_t nop();
        in_t v;
        v = '{default: 0};
        v.rst = 1'b1;
        v.memrdy = 1'b1;
        return v;
    endfunction

    function automatic out_t ex(bit sf, bit sd, bit se, bit sm, bit fd, bit fe,
                                bit [1:0] fa, bit [1:0] fb, bit b, bit [31:0] m);
        out_t o;
        o = {sf, sd, se, sm, fd, fe, fa, fb, b, m};
        return o;
    endfunction

    function automatic bit busy_reg(in_t v, bit [4:0] r);
        return (r != 0) && m_pend[r] && !(v.mddone && v.mdrdw == r);
    endfunction

    function automatic bit [1:0] fwd(in_t v, bit [4:0] r);
        if (r != 0 && v.rwm && v.rdm == r) return 2'b10;
        if (r != 0 && v.rww && v.rdw == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic out_t predict(in_t v);
        out_t o;
        bit raw, waw, lw, md, hold, win;
        o = '0;
        if (!v.rst) begin
            o.flushd = 1'b1;
            o.flushe = 1'b1;
            return o;
        end
        win  = (m_cnt > 0);
        raw  = (v.u1 && busy_reg(v, v.rs1d)) || (v.u2 && busy_reg(v, v.rs2d));
        waw  = v.rwd && busy_reg(v, v.rdd);
        lw   = (v.rsrc == 3'b001) && (v.rde != 0) &&
               ((v.u1 && v.rs1d == v.rde) || (v.u2 && v.rs2d == v.rde));
        md   = v.mdissue && m_busy && !v.mddone;
        hold = raw || waw || lw;
        if (!v.memrdy) begin
            {o.stallf, o.stalld, o.stalle, o.stallm} = 4'b1111;
            o.flushd = win;
            o.flushe = win;
        end else begin
            o.stallf = hold || md;
            o.stalld = hold || md;
            o.stalle = md;
            o.flushd = v.pcsrc || win;
            o.flushe = v.pcsrc || (hold && !md) || win;
        end
        o.fwda = fwd(v, v.rs1e);
        o.fwdb = fwd(v, v.rs2e);
        o.busy = m_busy;
        for (int r = 0; r < 32; r++) o.mask[r] = m_pend[r];
        return o;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
        m_busy = 1'b0;
        m_cnt  = RF;
    endtask

    task automatic model_clock(in_t v, out_t o);
        bit acc;
        if (!v.rst) return;
        acc = v.mdissue && !o.stalle && !o.flushe;
        if (v.mddone) begin
            m_pend[v.mdrdw] = 1'b0;
            m_busy = 1'b0;
        end
        if (acc) begin
            if (v.rde != 0) m_pend[v.rde] = 1'b1;
            m_busy = 1'b1;
        end
        if (m_cnt > 0) m_cnt--;
    endtask

    task automatic drive(in_t v);
        rst = v.rst; Rs1D = v.rs1d; Rs2D = v.rs2d; RdD = v.rdd; Rs1E = v.rs1e; Rs2E = v.rs2e;
        RdE = v.rde; RdM = v.rdm; RdW = v.rdw; MdRdW = v.mdrdw; UsesRs1D = v.u1; UsesRs2D = v.u2;
        RegWriteD = v.rwd; PCSrcE = v.pcsrc; MdIssueE = v.mdissue; RegWriteM = v.rwm;
        MemReadyM = v.memrdy; RegWriteW = v.rww; MdDoneW = v.mddone; ResultSrcE = v.rsrc;
    endtask

    // Called at a falling edge: drive, check mid-cycle, advance one clock.
    task automatic apply(in_t v, string nm, bit chk, out_t e);
        out_t got, want;
        drive(v);
        if (!v.rst) model_reset();
        #1;
        got  = {StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE, MdBusy, PendingMask};
        want = predict(v);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s (model): got %h expected %h", nm, got, want);
        end
        if (chk) begin
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL %s (table): got %h expected %h", nm, got, e);
            end
        end
        @(posedge clk);
        model_clock(v, want);
        @(negedge clk);
    endtask

    task automatic add(string nm, in_t v, out_t e);
        tbl.push_back('{nm, v, e});
    endtask

    initial begin
        in_t  v;
        out_t z0, fl, st4;
        z0  = ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
        fl  = ex(0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 32'h0);
        st4 = ex(1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 32'h0);

        // reset held with hazards present, then the flush window
        v = nop(); v.rst = 0; v.rs1e = 3; v.rwm = 1; v.rdm = 3; v.memrdy = 0; v.pcsrc = 1;
        add("rst_hold", v, fl);
        v = nop();
        add("win1", v, fl); add("win2", v, fl); add("win_end", v, z0);
        // div into x5, dependent decode waits until the result lands
        v = nop(); v.mdissue = 1; v.rde = 5; add("div_issue", v, z0);
        v = nop(); v.u1 = 1; v.rs1d = 5;
        add("raw_x5_a", v, ex(1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 1, 32'h20));
        add("raw_x5_b", v, ex(1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 1, 32'h20));
        v.mddone = 1; v.mdrdw = 5;
        add("raw_release", v, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 32'h20));
        v = nop(); add("div_done", v, z0);
        // WAW on a pending destination
        v = nop(); v.mdissue = 1; v.rde = 4; add("div_x4", v, z0);
        v = nop(); v.rwd = 1; v.rdd = 4;
        add("waw_x4", v, ex(1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 1, 32'h10));
        v.mddone = 1; v.mdrdw = 4;
        add("waw_release", v, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 32'h10));
        // load-use qualified by UsesRs2D
        v = nop(); v.rsrc = 3'b001; v.rde = 7; v.rs2d = 7;
        add("ld_nouse", v, z0);
        v.u2 = 1;
        add("ld_use", v, ex(1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 32'h0));
        // forwarding
        v = nop(); v.rwm = 1; v.rdm = 3; v.rww = 1; v.rdw = 3; v.rs1e = 3;
        add("fwd_m_prio", v, ex(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 32'h0));
        v.rs1e = 0;
        add("fwd_x0", v, z0);
        v = nop(); v.rdm = 9; v.rww = 1; v.rdw = 9; v.rs2e = 9;
        add("fwd_w", v, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 32'h0));
        // bus wait states with a pending redirect
        v = nop(); v.memrdy = 0; v.pcsrc = 1;
        add("freeze1", v, st4); add("freeze2", v, st4); add("freeze3", v, st4);
        v.memrdy = 1;
        add("unfreeze", v, fl);
        // second mul/div while busy, then async reset mid-op
        v = nop(); v.mdissue = 1; v.rde = 6; add("md1", v, z0);
        v.rde = 8;
        add("md2_stall_a", v, ex(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1, 32'h40));
        add("md2_stall_b", v, ex(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1, 32'h40));
        v.mddone = 1; v.mdrdw = 6;
        add("md2_go", v, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 32'h40));
        v = nop();
        add("md8_pend", v, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 32'h100));
        v.rst = 0;
        add("rst_mid", v, fl);
        v = nop();
        add("win1b", v, fl); add("win2b", v, fl); add("win_endb", v, z0);

        model_reset();
        @(negedge clk);
        foreach (tbl[k]) apply(tbl[k].i, tbl[k].nm, 1'b1, tbl[k].e);

        // randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            v = nop();
            v.rst     = ($urandom_range(0, 199) != 0);
            v.rs1d    = 5'($urandom_range(0, 7));
            v.rs2d    = 5'($urandom_range(0, 7));
            v.rdd     = 5'($urandom_range(0, 7));
            v.rs1e    = 5'($urandom_range(0, 7));
            v.rs2e    = 5'($urandom_range(0, 7));
            v.rde     = 5'($urandom_range(0, 7));
            v.rdm     = 5'($urandom_range(0, 7));
            v.rdw     = 5'($urandom_range(0, 7));
            v.mdrdw   = 5'($urandom_range(0, 7));
            v.u1      = 1'($urandom_range(0, 1));
            v.u2      = 1'($urandom_range(0, 1));
            v.rwd     = 1'($urandom_range(0, 1));
            v.rwm     = 1'($urandom_range(0, 1));
            v.rww     = 1'($urandom_range(0, 1));
            v.pcsrc   = ($urandom_range(0, 7) == 0);
            v.mdissue = ($urandom_range(0, 3) == 0);
            v.mddone  = ($urandom_range(0, 3) == 0);
            v.memrdy  = ($urandom_range(0, 7) != 0);
            v.rsrc    = 3'($urandom_range(0, 4));
            apply(v, "random", 1'b0, z0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
